adder_arbiter: RTL and testbench

Shares one combinational `ADDER` instance among `NUM_REQ` requesters, such as the PC-increment, branch-target and address-generation paths. Arbitration is round-robin, and each operation moves through a fixed three-state sequence: accept, compute, respond. Requests use a valid/ready handshake. Results are registered and tagged with the requester index.

---
 rtl/adder_arbiter_pkg.sv | 13 +
 rtl/adder_arbiter_adder.sv | 12 +
 rtl/adder_arbiter_rr_grant.sv | 38 +++
 rtl/adder_arbiter.sv | 100 ++++++++++
 tb/tb_adder_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the round-robin adder arbiter: FSM encoding and
// the priority pointer reset value.
package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RESPOND = 2'd2
  } arb_state_e;

  localparam int unsigned PRIO_PTR_RST = 0;

endpackage

// File: rtl/adder_arbiter_adder.sv
// Plain modular adder shared by all requesters; no carry out.
module ADDER #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/adder_arbiter_rr_grant.sv
// Combinational round-robin search: first valid index at or above ptr_i,
// wrapping modulo NUM_REQ.
module rr_grant #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  valid_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  grant_o,
  output logic [ID_WIDTH-1:0] idx_o,
  output logic                any_o
);

  logic [ID_WIDTH:0]   pos_sum;
  logic [ID_WIDTH-1:0] pos;

  // Walk from the lowest priority offset down so the nearest hit wins last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = |valid_i;
    pos_sum = '0;
    pos     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos_sum = {1'b0, ptr_i} + (ID_WIDTH + 1)'(k);
      if (pos_sum >= (ID_WIDTH + 1)'(NUM_REQ)) begin
        pos_sum = pos_sum - (ID_WIDTH + 1)'(NUM_REQ);
      end
      pos = pos_sum[ID_WIDTH-1:0];
      if (valid_i[pos]) begin
        grant_o      = '0;
        grant_o[pos] = 1'b1;
        idx_o        = pos;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// One shared ADDER serving NUM_REQ requesters round-robin through a fixed
// accept / compute / respond sequence with a registered, tagged result.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clock_in,
  input  logic                          reset_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic                          rsp_valid_out,
  output logic [ID_WIDTH-1:0]           rsp_id_out,
  output logic [DATA_WIDTH-1:0]         rsp_data_out,
  input  logic                          rsp_ready_in
);

  arb_state_e            state_q;
  logic [ID_WIDTH-1:0]   prio_ptr_q, prio_ptr_d;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  rsp_valid_q;
  logic [ID_WIDTH-1:0]   rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic [NUM_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic                  grant_any;
  logic [DATA_WIDTH-1:0] sum;

  rr_grant #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_grant (
    .valid_i (req_valid_in),
    .ptr_i   (prio_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  ADDER #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_adder (
    .a_i   (a_q),
    .b_i   (b_q),
    .sum_o (sum)
  );

  assign prio_ptr_d = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Reset gates the grant directly so ready is low while reset is held.
  assign req_ready_out = (state_q == ST_IDLE && !reset_in) ? grant : '0;
  assign rsp_valid_out = rsp_valid_q;
  assign rsp_id_out    = rsp_id_q;
  assign rsp_data_out  = rsp_data_q;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      prio_ptr_q  <= ID_WIDTH'(PRIO_PTR_RST);
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            a_q        <= req_a_in[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            b_q        <= req_b_in[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            id_q       <= grant_idx;
            prio_ptr_q <= prio_ptr_d;
            state_q    <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          rsp_data_q  <= sum;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (rsp_ready_in) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: directed stimulus pushes expected
// responses, a negedge monitor pops them on every response handshake.
module tb_adder_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int IW = 2;

  logic             clock_in = 1'b0;
  logic             reset_in;
  logic [NR-1:0]    req_valid_in;
  logic [NR*DW-1:0] req_a_in;
  logic [NR*DW-1:0] req_b_in;
  logic [NR-1:0]    req_ready_out;
  logic             rsp_valid_out;
  logic [IW-1:0]    rsp_id_out;
  logic [DW-1:0]    rsp_data_out;
  logic             rsp_ready_in;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [IW+DW-1:0] exp_q[$];
  logic [IW+DW-1:0] mon_exp;

  logic [DW-1:0] rr_a   [NR] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [DW-1:0] rr_b   [NR] = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};
  logic [DW-1:0] rr_sum [NR] = '{32'h11111112, 32'h22222224, 32'h33333336, 32'h44444448};

  adder_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .ID_WIDTH   (IW)
  ) dut (
    .clock_in      (clock_in),
    .reset_in      (reset_in),
    .req_valid_in  (req_valid_in),
    .req_a_in      (req_a_in),
    .req_b_in      (req_b_in),
    .req_ready_out (req_ready_out),
    .rsp_valid_out (rsp_valid_out),
    .rsp_id_out    (rsp_id_out),
    .rsp_data_out  (rsp_data_out),
    .rsp_ready_in  (rsp_ready_in)
  );

  always #5 clock_in = ~clock_in;
  always @(posedge clock_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every response handshake must match the oldest outstanding expectation.
  always @(negedge clock_in) begin
    if (!reset_in && rsp_valid_out && rsp_ready_in) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d data %0h expected no response",
                 rsp_id_out, rsp_data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rsp_id", 64'(rsp_id_out), 64'(mon_exp[DW +: IW]));
        check("rsp_data", 64'(rsp_data_out), 64'(mon_exp[DW-1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid_in[i]       = 1'b1;
    req_a_in[i*DW +: DW]  = a;
    req_b_in[i*DW +: DW]  = b;
  endtask

  task automatic clear_reqs();
    req_valid_in = '0;
    req_a_in     = '0;
    req_b_in     = '0;
  endtask

  // Waits for the next accept cycle, checks the one-hot ready, optionally
  // queues the expected response, and returns one edge later (+1).
  task automatic accept(input logic [NR-1:0] exp_oh, input logic [IW-1:0] exp_id,
                        input logic [DW-1:0] exp_sum, input bit push,
                        input string name, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    @(negedge clock_in);
    while (req_ready_out == '0 && n < 20) begin
      n++;
      @(negedge clock_in);
    end
    if (req_ready_out == '0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ready expected %b", name, exp_oh);
    end else begin
      check({name, "_ready"}, 64'(req_ready_out), 64'(exp_oh));
      acc_cyc = cyc;
      if (push) exp_q.push_back({exp_id, exp_sum});
    end
    @(posedge clock_in);
    #1;
  endtask

  task automatic wait_rsp_valid(input string name);
    int n;
    n = 0;
    @(negedge clock_in);
    while (!rsp_valid_out && n < 20) begin
      n++;
      @(negedge clock_in);
    end
    if (!rsp_valid_out) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got rsp_valid 0 expected 1", name);
    end
  endtask

  initial begin
    int c, prev, hs, n;
    reset_in     = 1'b1;
    rsp_ready_in = 1'b0;
    clear_reqs();
    req_valid_in = '1;

    // Reset state, with requests pending to show ready is suppressed.
    repeat (2) @(negedge clock_in);
    check("rst_ready", 64'(req_ready_out), 64'(0));
    check("rst_valid", 64'(rsp_valid_out), 64'(0));
    check("rst_id", 64'(rsp_id_out), 64'(0));
    check("rst_data", 64'(rsp_data_out), 64'(0));
    clear_reqs();
    @(negedge clock_in);
    reset_in = 1'b0;
    @(posedge clock_in);
    #1;
    rsp_ready_in = 1'b1;

    // Single request from requester 2: 5 + 3, result two cycles after accept.
    set_req(2, 32'h0000_0005, 32'h0000_0003);
    accept(4'b0100, 2'd2, 32'h0000_0008, 1'b1, "single", c);
    clear_reqs();
    @(negedge clock_in);
    check("single_compute_valid", 64'(rsp_valid_out), 64'(0));
    check("single_compute_ready", 64'(req_ready_out), 64'(0));
    @(negedge clock_in);
    check("single_latency_valid", 64'(rsp_valid_out), 64'(1));
    @(posedge clock_in);
    #1;

    // Wrap-around sum; pointer is at 3 so requester 0 is found after wrapping.
    set_req(0, 32'hFFFF_FFFF, 32'h0000_0002);
    accept(4'b0001, 2'd0, 32'h0000_0001, 1'b1, "wrap", c);
    clear_reqs();
    wait_rsp_valid("wrap_rsp");
    @(posedge clock_in);
    #1;

    // Asynchronous reset while holding a response for requester 1.
    rsp_ready_in = 1'b0;
    set_req(1, 32'h0000_0005, 32'h0000_0006);
    accept(4'b0010, 2'd1, 32'h0000_000B, 1'b0, "rst_acc", c);
    clear_reqs();
    wait_rsp_valid("rst_rsp");
    check("pre_rst_id", 64'(rsp_id_out), 64'(1));
    @(posedge clock_in);
    #2;
    reset_in = 1'b1;
    #1;
    check("midrst_valid", 64'(rsp_valid_out), 64'(0));
    check("midrst_id", 64'(rsp_id_out), 64'(0));
    check("midrst_data", 64'(rsp_data_out), 64'(0));
    check("midrst_ready", 64'(req_ready_out), 64'(0));
    @(negedge clock_in);
    @(negedge clock_in);
    reset_in     = 1'b0;
    rsp_ready_in = 1'b1;
    @(posedge clock_in);
    #1;

    // Round-robin from a reset pointer: ids 0,1,2,3,0 spaced 3 cycles apart.
    for (int i = 0; i < NR; i++) set_req(i, rr_a[i], rr_b[i]);
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      accept(4'(1 << (k % NR)), 2'(k % NR), rr_sum[k % NR], 1'b1, "rr", c);
      if (k > 0) check("rr_spacing", 64'(c - prev), 64'(3));
      prev = c;
    end
    clear_reqs();
    rsp_ready_in = 1'b0;

    // Backpressure: response for requester 0 held, no accept while waiting.
    wait_rsp_valid("bp_rsp");
    set_req(3, 32'hDEAD_0000, 32'h0000_BEEF);
    @(posedge clock_in);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock_in);
      check("bp_valid", 64'(rsp_valid_out), 64'(1));
      check("bp_id", 64'(rsp_id_out), 64'(0));
      check("bp_data", 64'(rsp_data_out), 64'(32'h11111112));
      check("bp_ready", 64'(req_ready_out), 64'(0));
    end
    @(posedge clock_in);
    #1;
    rsp_ready_in = 1'b1;
    @(negedge clock_in);
    hs = cyc;
    accept(4'b1000, 2'd3, 32'hDEAD_BEEF, 1'b1, "bp_next", c);
    check("bp_next_cycle", 64'(c - hs), 64'(1));
    clear_reqs();

    // Withdrawal: requester 1 drops out during requester 0's compute.
    set_req(0, 32'h0000_0100, 32'h0000_0023);
    set_req(1, 32'h0000_0200, 32'h0000_0045);
    accept(4'b0001, 2'd0, 32'h0000_0123, 1'b1, "wd_first", c);
    clear_reqs();
    set_req(3, 32'h7000_0000, 32'h1000_0000);
    accept(4'b1000, 2'd3, 32'h8000_0000, 1'b1, "wd_next", c);
    clear_reqs();

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(negedge clock_in);
    end
    check("drain_pending", 64'(exp_q.size()), 64'(0));
    repeat (3) @(negedge clock_in);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
